// File: rtl/hazard_ctrl_mc.sv
// Load-use hazard and pipeline-freeze controller for the 5-stage MIPS pipeline.
// It issues a multi-cycle load-use stall, freezes on data-memory wait, arbitrates taken-branch flush and counts stall cycles.
module hazard_ctrl_mc #(
  parameter int REG_W      = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_ex_mem_read_i,
  input  logic [REG_W-1:0]  id_ex_rt_i,
  input  logic [REG_W-1:0]  if_id_rs_i,
  input  logic [REG_W-1:0]  if_id_rt_i,
  input  logic              if_id_uses_rt_i,
  input  logic              branch_taken_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ready_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              bubble_o,
  output logic              mem_stall_o,
  output logic [PERF_W-1:0] stall_count_o
);

  typedef enum logic {
    ST_IDLE,
    ST_LU_STALL
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PERF_W-1:0]  r_stall_count;

  logic w_freeze;
  logic w_hazard;
  logic w_rs_match;
  logic w_rt_match;

  assign w_freeze   = dmem_req_i & ~dmem_ready_i;
  assign w_rs_match = (id_ex_rt_i == if_id_rs_i);
  assign w_rt_match = if_id_uses_rt_i & (id_ex_rt_i == if_id_rt_i);
  // A load into $0 never creates a real dependency.
  assign w_hazard   = id_ex_mem_read_i & (id_ex_rt_i != '0) & (w_rs_match | w_rt_match);

  // NOTE: every output gets a default first, so no path through this block can infer a latch.
  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    bubble_o      = 1'b0;
    mem_stall_o   = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end else if (w_freeze) begin
      mem_stall_o   = 1'b1;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end else if ((r_state == ST_LU_STALL) || w_hazard) begin
      // A pending hazard wins over a taken branch because the branch operands are stale.
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      bubble_o      = 1'b1;
    end else if (branch_taken_i) begin
      if_id_flush_o = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_stall_count <= '0;
    end else begin
      if (!pc_write_o && (r_stall_count != {PERF_W{1'b1}})) begin
        r_stall_count <= r_stall_count + PERF_W'(1);
      end
      // The detect cycle is the first bubble; LU_STALL supplies the remaining LOAD_STALL-1.
      if (!w_freeze) begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_hazard && (LOAD_STALL > 1)) begin
              r_state <= ST_LU_STALL;
              r_cnt   <= CNT_W'(LOAD_STALL - 1);
            end
          end
          ST_LU_STALL: begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign stall_count_o = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: three instances (LOAD_STALL=1, LOAD_STALL=3, PERF_W=4)
// share the stimulus; each scenario task checks the instance it targets.
module tb_hazard_ctrl_mc;

  logic       clk;
  logic       rst;
  logic       mem_read;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       uses_rt;
  logic       br_taken;
  logic       dreq;
  logic       drdy;

  logic        a_pc, a_ifw, a_flush, a_bub, a_mst;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifw, b_flush, b_bub, b_mst;
  logic [15:0] b_cnt;
  logic        c_pc, c_ifw, c_flush, c_bub, c_mst;
  logic [3:0]  c_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl_mc #(.REG_W(5), .LOAD_STALL(1), .CNT_W(3), .PERF_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_ex_mem_read_i(mem_read), .id_ex_rt_i(ex_rt),
    .if_id_rs_i(id_rs), .if_id_rt_i(id_rt), .if_id_uses_rt_i(uses_rt),
    .branch_taken_i(br_taken), .dmem_req_i(dreq), .dmem_ready_i(drdy),
    .pc_write_o(a_pc), .if_id_write_o(a_ifw), .if_id_flush_o(a_flush),
    .bubble_o(a_bub), .mem_stall_o(a_mst), .stall_count_o(a_cnt));

  hazard_ctrl_mc #(.REG_W(5), .LOAD_STALL(3), .CNT_W(3), .PERF_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_ex_mem_read_i(mem_read), .id_ex_rt_i(ex_rt),
    .if_id_rs_i(id_rs), .if_id_rt_i(id_rt), .if_id_uses_rt_i(uses_rt),
    .branch_taken_i(br_taken), .dmem_req_i(dreq), .dmem_ready_i(drdy),
    .pc_write_o(b_pc), .if_id_write_o(b_ifw), .if_id_flush_o(b_flush),
    .bubble_o(b_bub), .mem_stall_o(b_mst), .stall_count_o(b_cnt));

  hazard_ctrl_mc #(.REG_W(5), .LOAD_STALL(1), .CNT_W(3), .PERF_W(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .id_ex_mem_read_i(mem_read), .id_ex_rt_i(ex_rt),
    .if_id_rs_i(id_rs), .if_id_rt_i(id_rt), .if_id_uses_rt_i(uses_rt),
    .branch_taken_i(br_taken), .dmem_req_i(dreq), .dmem_ready_i(drdy),
    .pc_write_o(c_pc), .if_id_write_o(c_ifw), .if_id_flush_o(c_flush),
    .bubble_o(c_bub), .mem_stall_o(c_mst), .stall_count_o(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ur, input logic br,
                        input logic rq, input logic rd);
    mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    uses_rt = ur; br_taken = br; dreq = rq; drdy = rd;
    #1;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 5'd8, 5'd8, 0, 0, 1, 1, 0);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({b_pc, b_ifw, b_flush, b_bub, b_mst} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {b_pc, b_ifw, b_flush, b_bub, b_mst});
    end
    tick();
    n_chk++;
    if (b_cnt !== 16'd0 || a_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d/%0d expected 0", a_cnt, b_cnt);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({b_pc, b_ifw, b_flush, b_bub, b_mst} !== 5'b11000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected 11000", {b_pc, b_ifw, b_flush, b_bub, b_mst});
    end
  endtask

  task automatic test_load_stall_1();
    do_reset();
    set_in(1, 5'd8, 5'd8, 5'd2, 0, 0, 0, 0);
    n_chk++;
    if (a_bub !== 1'b1 || a_pc !== 1'b0 || a_ifw !== 1'b0) begin
      n_fail++;
      $display("FAIL ls1_detect: bub=%b pc=%b ifw=%b expected 1 0 0", a_bub, a_pc, a_ifw);
    end
    tick();
    set_in(0, 5'd8, 5'd8, 5'd2, 0, 0, 0, 0);
    n_chk++;
    if (a_bub !== 1'b0 || a_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL ls1_release: bub=%b pc=%b expected 0 1", a_bub, a_pc);
    end
    tick();
    n_chk++;
    if (a_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL ls1_count: got %0d expected 1", a_cnt);
    end
  endtask

  task automatic test_load_stall_3();
    logic exp_bub [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    set_in(1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (b_bub !== exp_bub[i] || b_pc !== ~exp_bub[i]) begin
        n_fail++;
        $display("FAIL ls3_cycle%0d: bub=%b pc=%b expected bub=%b", i, b_bub, b_pc, exp_bub[i]);
      end
      tick();
      set_in(0, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0);
    end
    n_chk++;
    if (b_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL ls3_count: got %0d expected 3", b_cnt);
    end
    set_in(1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0);
    n_chk++;
    if (b_bub !== 1'b0 || b_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL ls3_rt_unused: bub=%b pc=%b expected 0 1", b_bub, b_pc);
    end
  endtask

  task automatic test_zero_and_branch();
    do_reset();
    set_in(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    n_chk++;
    if (b_bub !== 1'b0 || b_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_reg: bub=%b pc=%b expected 0 1", b_bub, b_pc);
    end
    set_in(0, 5'd4, 5'd4, 5'd0, 0, 1, 0, 0);
    n_chk++;
    if ({b_flush, b_pc, b_ifw, b_bub, b_mst} !== 5'b11100) begin
      n_fail++;
      $display("FAIL branch_flush: got %b expected 11100", {b_flush, b_pc, b_ifw, b_bub, b_mst});
    end
  endtask

  task automatic test_freeze_in_stall();
    logic exp_bub [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_mst [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_pc  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in((i == 0), 5'd9, 5'd9, 5'd0, 0, 0, (i == 2 || i == 3), 1'b0);
      n_chk++;
      if (b_bub !== exp_bub[i] || b_mst !== exp_mst[i] || b_pc !== exp_pc[i]) begin
        n_fail++;
        $display("FAIL freeze_stall_c%0d: bub=%b mst=%b pc=%b expected %b %b %b",
                 i, b_bub, b_mst, b_pc, exp_bub[i], exp_mst[i], exp_pc[i]);
      end
      tick();
    end
    n_chk++;
    if (b_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL freeze_stall_count: got %0d expected 5", b_cnt);
    end
  endtask

  task automatic test_freeze_at_detect();
    do_reset();
    set_in(1, 5'd7, 5'd7, 5'd0, 0, 0, 1, 0);
    n_chk++;
    if (b_bub !== 1'b0 || b_mst !== 1'b1 || b_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_detect: bub=%b mst=%b pc=%b expected 0 1 0", b_bub, b_mst, b_pc);
    end
    tick();
    set_in(1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0);
    n_chk++;
    if (b_bub !== 1'b1 || b_mst !== 1'b0) begin
      n_fail++;
      $display("FAIL redetect: bub=%b mst=%b expected 1 0", b_bub, b_mst);
    end
    tick();
    set_in(0, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0);
    tick();
    tick();
    n_chk++;
    if (b_bub !== 1'b0 || b_pc !== 1'b1 || b_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL redetect_end: bub=%b pc=%b cnt=%0d expected 0 1 4", b_bub, b_pc, b_cnt);
    end
  endtask

  task automatic test_branch_hazard_and_reset();
    do_reset();
    set_in(1, 5'd6, 5'd6, 5'd0, 0, 1, 0, 0);
    n_chk++;
    if (b_bub !== 1'b1 || b_flush !== 1'b0 || b_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_vs_branch: bub=%b flush=%b pc=%b expected 1 0 0", b_bub, b_flush, b_pc);
    end
    tick();
    set_in(0, 5'd6, 5'd6, 5'd0, 0, 1, 0, 0);
    n_chk++;
    if (b_bub !== 1'b1 || b_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hides_branch: bub=%b flush=%b expected 1 0", b_bub, b_flush);
    end
    tick();
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({b_pc, b_ifw, b_flush, b_bub, b_mst} !== 5'b0 || b_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_stall_reset: out=%b cnt=%0d expected 00000 0",
               {b_pc, b_ifw, b_flush, b_bub, b_mst}, b_cnt);
    end
    #1;
    rst = 1'b0;
    tick();
    n_chk++;
    if (b_pc !== 1'b1 || b_bub !== 1'b0 || b_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL after_reset: pc=%b bub=%b cnt=%0d expected 1 0 0", b_pc, b_bub, b_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_chk++;
      if (c_cnt !== ((i < 15) ? 4'(i) : 4'd15)) begin
        n_fail++;
        $display("FAIL saturate_c%0d: got %0d expected %0d", i, c_cnt, (i < 15) ? i : 15);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_stall_1();
    test_load_stall_3();
    test_zero_and_branch();
    test_freeze_in_stall();
    test_freeze_at_detect();
    test_branch_hazard_and_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
